// File: rtl/fft_out_pkg.sv
// Shared types and helpers for the FFT output stream buffer.
// Build option: FFT_OUT_ROUND_EN selects rounding instead of truncation (see fft_scale_shift).
package fft_out_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Source bin for output slot j: natural order, or k -> (n-k) mod n (bin 0 stays put).
  function automatic int unsigned src_index(input int unsigned j, input logic reorder_en,
                                            input int unsigned n);
    if (reorder_en) begin
      return (n - j) % n;
    end else begin
      return j;
    end
  endfunction

endpackage

// File: rtl/fft_scale_shift.sv
// Scales one W-bit two's-complement part by 2^-SHIFT.
// Default build truncates toward zero; with FFT_OUT_ROUND_EN defined it rounds half away
// from zero and saturates positive overflow. Purely combinational.
module fft_scale_shift #(
  parameter int W     = 16,
  parameter int SHIFT = 4
) (
  input  logic signed [W-1:0] part,
  output logic signed [W-1:0] scaled
);

  logic          neg_s;
  logic [W-1:0]  neg_part_s;
  logic [W-1:0]  mag_s;

  assign neg_s      = part[W-1];
  assign neg_part_s = -part;
  // Magnitude as unsigned W bits; -2^(W-1) maps to 2^(W-1) with no overflow.
  assign mag_s      = neg_s ? neg_part_s : part;

`ifdef FFT_OUT_ROUND_EN
  localparam logic [W:0] HALF_LP = (W+1)'((2 ** SHIFT) / 2);
  localparam logic [W:0] MAX_LP  = (W+1)'((2 ** (W-1)) - 1);

  logic [W:0] sum_s;
  logic [W:0] rnd_s;

  // Round magnitude half away from zero, then restore sign with positive saturation.
  always_comb begin
    sum_s = {1'b0, mag_s} + HALF_LP;
    rnd_s = sum_s >> SHIFT;
    if (!neg_s && (rnd_s > MAX_LP)) begin
      scaled = MAX_LP[W-1:0];
    end else if (neg_s) begin
      scaled = -rnd_s[W-1:0];
    end else begin
      scaled = rnd_s[W-1:0];
    end
  end
`else
  logic [W-1:0] shifted_s;

  // Shift the magnitude, then restore sign: truncation toward zero.
  always_comb begin
    shifted_s = mag_s >> SHIFT;
    if (neg_s) begin
      scaled = -shifted_s;
    end else begin
      scaled = shifted_s;
    end
  end
`endif

endmodule

// File: rtl/fft_out_stream_buf.sv
// FFT output stage: captures a full frame of N complex bins, scales every part, optionally
// reorders k -> (N-k) mod N, and streams one bin per beat over valid/ready.
// Build option: FFT_OUT_ROUND_EN (rounding scale, handled in fft_scale_shift).
module fft_out_stream_buf
  import fft_out_pkg::*;
#(
  parameter int N     = 16,
  parameter int W     = 16,
  parameter int SHIFT = 4,
  parameter int IDXW  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*W-1:0]    in_re,
  input  logic [N*W-1:0]    in_im,
  input  logic              reorder_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_re,
  output logic [W-1:0]      out_im,
  output logic [IDXW-1:0]   out_idx,
  output logic              out_last
);

  state_e              state_r;
  state_e              state_nx_s;
  logic signed [W-1:0] sc_re_s  [N];
  logic signed [W-1:0] sc_im_s  [N];
  logic signed [W-1:0] cap_re_s [N];
  logic signed [W-1:0] cap_im_s [N];
  logic signed [W-1:0] mem_re_r [N];
  logic signed [W-1:0] mem_im_r [N];
  logic [IDXW-1:0]     src_s;
  logic [IDXW-1:0]     nxt_idx_s;
  logic                xfer_s;
  logic                cap_s;

  // Scale every incoming part before capture.
  for (genvar k = 0; k < N; k++) begin : g_scale
    fft_scale_shift #(.W(W), .SHIFT(SHIFT)) u_re (.part(in_re[k*W +: W]), .scaled(sc_re_s[k]));
    fft_scale_shift #(.W(W), .SHIFT(SHIFT)) u_im (.part(in_im[k*W +: W]), .scaled(sc_im_s[k]));
  end

  assign xfer_s    = out_valid && out_ready;
  assign in_ready  = (state_r == IDLE) || (xfer_s && out_last);
  assign cap_s     = in_valid && in_ready;
  assign nxt_idx_s = out_idx + {{(IDXW-1){1'b0}}, 1'b1};

  // Place scaled bins into output order according to the reorder mode.
  always_comb begin
    src_s = '0;
    for (int unsigned j = 0; j < N; j++) begin
      src_s       = IDXW'(src_index(j, reorder_en, N));
      cap_re_s[j] = sc_re_s[src_s];
      cap_im_s[j] = sc_im_s[src_s];
    end
  end

  // Next-state: a capture always (re)starts streaming; the last transfer alone ends it.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (cap_s) begin
          state_nx_s = STREAM;
        end else begin
          state_nx_s = IDLE;
        end
      end
      STREAM: begin
        if (cap_s) begin
          state_nx_s = STREAM;
        end else if (xfer_s && out_last) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = STREAM;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, frame storage and registered beat outputs (loaded from storage at the next index).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_re    <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        mem_re_r[i] <= '0;
        mem_im_r[i] <= '0;
      end
    end else begin
      state_r   <= state_nx_s;
      out_valid <= (state_nx_s == STREAM);
      if (cap_s) begin
        mem_re_r <= cap_re_s;
        mem_im_r <= cap_im_s;
        out_idx  <= '0;
        out_re   <= cap_re_s[0];
        out_im   <= cap_im_s[0];
        out_last <= 1'b0;
      end else if (xfer_s && out_last) begin
        out_idx  <= '0;
        out_last <= 1'b0;
      end else if (xfer_s) begin
        out_idx  <= nxt_idx_s;
        out_re   <= mem_re_r[nxt_idx_s];
        out_im   <= mem_im_r[nxt_idx_s];
        out_last <= (nxt_idx_s == IDXW'(N - 1));
      end
    end
  end

endmodule
